// File: rtl/mpi_eth_stimulator.sv
// MPI-over-Ethernet traffic generator and reply checker: sends NUM_PKTS tagged
// messages on a 64-bit AXI-Stream and checks each loopback reply beat by beat.
module mpi_eth_stimulator #(
    parameter int unsigned NUM_PKTS      = 4,
    parameter int unsigned PAYLOAD_BYTES = 60,
    parameter logic [7:0]  SRC_RANK      = 8'h01,
    parameter logic [7:0]  DEST_RANK     = 8'h02,
    parameter int unsigned START_DELAY   = 16,
    parameter int unsigned GAP_CYCLES    = 4,
    parameter bit          RX_THROTTLE   = 1'b0,
    parameter int unsigned TIMEOUT       = 4096
) (
    input  logic        clk,
    input  logic        aux_resetn,
    output logic [63:0] stream_out_DATA,
    output logic [7:0]  stream_out_KEEP,
    output logic        stream_out_LAST,
    output logic        stream_out_VALID,
    input  logic        stream_out_READY,
    input  logic [63:0] stream_in_DATA,
    input  logic [7:0]  stream_in_KEEP,
    input  logic        stream_in_LAST,
    input  logic        stream_in_VALID,
    output logic        stream_in_READY,
    output logic        done,
    output logic        pass,
    output logic [15:0] err_count,
    output logic [15:0] rx_pkt_count
);

    localparam int unsigned NUM_BEATS = (PAYLOAD_BYTES + 7) / 8;
    localparam int unsigned REM_BYTES = PAYLOAD_BYTES % 8;
    localparam logic [7:0]  LAST_KEEP = (REM_BYTES == 0) ? 8'hFF : 8'((1 << REM_BYTES) - 1);

    typedef enum logic [2:0] {S_WAIT, S_HDR, S_PAY, S_GAP, S_TXDONE} tx_state_t;

    tx_state_t   state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [15:0] tag_q, tag_d;
    logic [15:0] beat_q, beat_d;
    logic        en_q, en_d;
    logic [1:0]  thr_q, thr_d;
    logic [15:0] rx_beat_q, rx_beat_d;
    logic        resync_q, resync_d;
    logic [15:0] err_q, err_d;
    logic [15:0] pkt_q, pkt_d;
    logic        done_q, done_d;
    logic        timed_out_q, timed_out_d;
    logic        pass_q, pass_d;

    logic        timeout_hit;
    logic        rx_fire;
    logic        beat_err;
    logic        exp_last;
    logic [63:0] exp_data;
    logic [7:0]  exp_keep;

    // TX sequencer; beat contents decode straight from registered state so
    // they cannot change while a stalled beat waits for READY.
    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        tag_d            = tag_q;
        beat_d           = beat_q;
        stream_out_DATA  = '0;
        stream_out_KEEP  = '0;
        stream_out_LAST  = 1'b0;
        stream_out_VALID = 1'b0;
        case (state_q)
            S_WAIT, S_GAP: begin
                if (cnt_q + 32'd1 >= ((state_q == S_WAIT) ? START_DELAY : GAP_CYCLES)) begin
                    state_d = S_HDR;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_HDR: begin
                stream_out_VALID = 1'b1;
                stream_out_KEEP  = 8'hFF;
                stream_out_DATA  = {DEST_RANK, SRC_RANK, 16'(PAYLOAD_BYTES), tag_q, 16'hA5A5};
                if (stream_out_READY) begin
                    state_d = S_PAY;
                    beat_d  = '0;
                end
            end
            S_PAY: begin
                stream_out_VALID = 1'b1;
                stream_out_LAST  = (beat_q == 16'(NUM_BEATS - 1));
                stream_out_KEEP  = stream_out_LAST ? LAST_KEEP : 8'hFF;
                stream_out_DATA  = {16'hDA7A, tag_q, 16'h0000, beat_q};
                if (stream_out_READY) begin
                    if (stream_out_LAST) begin
                        beat_d = '0;
                        cnt_d  = '0;
                        if (tag_q == 16'(NUM_PKTS - 1)) begin
                            state_d = S_TXDONE;
                        end else begin
                            state_d = S_GAP;
                            tag_d   = tag_q + 16'd1;
                        end
                    end else begin
                        beat_d = beat_q + 16'd1;
                    end
                end
            end
            S_TXDONE: begin
                if (!done_q) cnt_d = cnt_q + 32'd1;
            end
            default: state_d = S_WAIT;
        endcase
    end

    assign timeout_hit     = (state_q == S_TXDONE) && !done_q && (cnt_q + 32'd1 >= TIMEOUT);
    assign stream_in_READY = en_q & ~(RX_THROTTLE & (thr_q == 2'd3));
    assign rx_fire         = stream_in_VALID & stream_in_READY;

    // Reply checker; rx_beat_q = 0 is the header, k > 0 is payload beat k-1.
    always_comb begin
        en_d        = 1'b1;
        thr_d       = thr_q + 2'd1;
        rx_beat_d   = rx_beat_q;
        resync_d    = resync_q;
        err_d       = err_q;
        pkt_d       = pkt_q;
        beat_err    = 1'b0;
        exp_last    = (rx_beat_q == 16'(NUM_BEATS));
        exp_keep    = 8'hFF;
        exp_data    = {SRC_RANK, DEST_RANK, 16'(PAYLOAD_BYTES), pkt_q, 16'hA5A5};
        if (rx_beat_q != 16'd0) begin
            exp_data = {16'hDA7A, pkt_q, 16'h0000, 16'(rx_beat_q - 16'd1)};
            exp_keep = exp_last ? LAST_KEEP : 8'hFF;
        end
        if (rx_fire) begin
            if (done_q) begin
                beat_err = 1'b1;
            end else if (resync_q) begin
                if (stream_in_LAST) begin
                    resync_d  = 1'b0;
                    rx_beat_d = '0;
                end
            end else begin
                beat_err = (stream_in_DATA != exp_data) || (stream_in_KEEP != exp_keep) ||
                           (stream_in_LAST != exp_last);
                if (stream_in_LAST) begin
                    rx_beat_d = '0;
                end else if (exp_last) begin
                    resync_d  = 1'b1;
                    rx_beat_d = '0;
                end else begin
                    rx_beat_d = rx_beat_q + 16'd1;
                end
            end
            if (stream_in_LAST) pkt_d = pkt_q + 16'd1;
        end
        if (beat_err && (err_q != 16'hFFFF)) err_d = err_q + 16'd1;
        done_d      = done_q | (pkt_d == 16'(NUM_PKTS)) | timeout_hit;
        timed_out_d = timed_out_q | (timeout_hit & (pkt_d != 16'(NUM_PKTS)));
        pass_d      = done_d & ~timed_out_d & (err_d == 16'd0);
    end

    always_ff @(posedge clk or negedge aux_resetn) begin
        if (!aux_resetn) begin
            state_q     <= S_WAIT;
            cnt_q       <= '0;
            tag_q       <= '0;
            beat_q      <= '0;
            en_q        <= 1'b0;
            thr_q       <= '0;
            rx_beat_q   <= '0;
            resync_q    <= 1'b0;
            err_q       <= '0;
            pkt_q       <= '0;
            done_q      <= 1'b0;
            timed_out_q <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tag_q       <= tag_d;
            beat_q      <= beat_d;
            en_q        <= en_d;
            thr_q       <= thr_d;
            rx_beat_q   <= rx_beat_d;
            resync_q    <= resync_d;
            err_q       <= err_d;
            pkt_q       <= pkt_d;
            done_q      <= done_d;
            timed_out_q <= timed_out_d;
            pass_q      <= pass_d;
        end
    end

    assign done         = done_q;
    assign pass         = pass_q;
    assign err_count    = err_q;
    assign rx_pkt_count = pkt_q;

endmodule

// File: tb/tb_mpi_eth_stimulator.sv
// Bench for mpi_eth_stimulator: the bench plays the loopback DUT with random
// stalls and checks TX beats, reply checking, throttling, timeout and reset.
module tb_mpi_eth_stimulator;

    localparam int NP = 4;
    localparam int PB = 60;
    localparam int SD = 16;
    localparam int GC = 4;
    localparam int TO = 4096;
    localparam int NB = (PB + 7) / 8;
    localparam logic [7:0] SRC = 8'h01;
    localparam logic [7:0] DST = 8'h02;

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        aux_resetn = 1'b1;
    logic        sel = 1'b0;
    logic        so_ready = 1'b0;
    logic [63:0] si_data = '0;
    logic [7:0]  si_keep = '0;
    logic        si_last = 1'b0;
    logic        si_valid = 1'b0;

    logic [63:0] so_data0, so_data1;
    logic [7:0]  so_keep0, so_keep1;
    logic        so_last0, so_last1, so_valid0, so_valid1;
    logic        si_ready0, si_ready1, done0, done1, pass0, pass1;
    logic [15:0] err0, err1, pkt0, pkt1;
    logic        so_ready0, so_ready1, si_valid0, si_valid1;

    assign so_ready0 = sel ? 1'b0 : so_ready;
    assign so_ready1 = sel ? so_ready : 1'b0;
    assign si_valid0 = sel ? 1'b0 : si_valid;
    assign si_valid1 = sel ? si_valid : 1'b0;

    wire [63:0] so_data  = sel ? so_data1  : so_data0;
    wire [7:0]  so_keep  = sel ? so_keep1  : so_keep0;
    wire        so_last  = sel ? so_last1  : so_last0;
    wire        so_valid = sel ? so_valid1 : so_valid0;
    wire        si_ready = sel ? si_ready1 : si_ready0;
    wire        done_o   = sel ? done1     : done0;
    wire        pass_o   = sel ? pass1     : pass0;
    wire [15:0] err_o    = sel ? err1      : err0;
    wire [15:0] pkt_o    = sel ? pkt1      : pkt0;

    mpi_eth_stimulator #(.RX_THROTTLE(1'b0)) dut (
        .clk(clk), .aux_resetn(aux_resetn),
        .stream_out_DATA(so_data0), .stream_out_KEEP(so_keep0), .stream_out_LAST(so_last0),
        .stream_out_VALID(so_valid0), .stream_out_READY(so_ready0),
        .stream_in_DATA(si_data), .stream_in_KEEP(si_keep), .stream_in_LAST(si_last),
        .stream_in_VALID(si_valid0), .stream_in_READY(si_ready0),
        .done(done0), .pass(pass0), .err_count(err0), .rx_pkt_count(pkt0)
    );

    mpi_eth_stimulator #(.RX_THROTTLE(1'b1)) dut_thr (
        .clk(clk), .aux_resetn(aux_resetn),
        .stream_out_DATA(so_data1), .stream_out_KEEP(so_keep1), .stream_out_LAST(so_last1),
        .stream_out_VALID(so_valid1), .stream_out_READY(so_ready1),
        .stream_in_DATA(si_data), .stream_in_KEEP(si_keep), .stream_in_LAST(si_last),
        .stream_in_VALID(si_valid1), .stream_in_READY(si_ready1),
        .done(done1), .pass(pass1), .err_count(err1), .rx_pkt_count(pkt1)
    );

    int total = 0;
    int bad   = 0;

    beat_t exp_q[$];
    beat_t tx_q[$];
    beat_t rep_q[$];
    int    cyc = 0;
    int    stall_viol, thr_viol, thr_lows, last_low, loop_cycles;
    int    last_tx_cyc, done_cyc;

    // Reference message stream built from the packet format rules.
    task automatic build_expected();
        beat_t b;
        int    left;
        exp_q.delete();
        for (int t = 0; t < NP; t++) begin
            b.d = {DST, SRC, 16'(PB), 16'(t), 16'hA5A5};
            b.k = 8'hFF;
            b.l = 1'b0;
            exp_q.push_back(b);
            for (int i = 0; i < NB; i++) begin
                left = PB - 8 * i;
                b.d = {16'hDA7A, 16'(t), 32'(i)};
                b.k = (left >= 8) ? 8'hFF : 8'((1 << left) - 1);
                b.l = (left <= 8);
                exp_q.push_back(b);
            end
        end
    endtask

    task automatic clear_tb();
        tx_q.delete();
        rep_q.delete();
        stall_viol = 0; thr_viol = 0; thr_lows = 0; loop_cycles = 0;
        last_tx_cyc = -1; done_cyc = -1;
        so_ready = 1'b0; si_valid = 1'b0; si_data = '0; si_keep = '0; si_last = 1'b0;
    endtask

    task automatic do_reset();
        aux_resetn = 1'b0;
        clear_tb();
        repeat (3) @(negedge clk);
        aux_resetn = 1'b1;
    endtask

    // mode 0 = loopback, 1 = corrupt tag 1 payload beat 2 bit 0, 2 = never reply
    task automatic run_loop(input int mode, input bit stall, input bit rx_gaps,
                            input int stop_tx, input int budget);
        bit    prev_stall = 1'b0;
        beat_t prev_b = '0;
        beat_t cur, r;
        int    pbeat = 0;
        int    ptag  = 0;
        last_low = -1;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            cyc++;
            loop_cycles++;
            cur = {so_data, so_keep, so_last};
            if (prev_stall && (!so_valid || cur !== prev_b)) stall_viol++;
            if (!si_ready) begin
                thr_lows++;
                if (last_low >= 0 && cyc - last_low != 4) thr_viol++;
                last_low = cyc;
            end
            if (done_o || (stop_tx > 0 && tx_q.size() >= stop_tx)) begin
                done_cyc = cyc;
                so_ready = 1'b0;
                si_valid = 1'b0;
                break;
            end
            so_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (so_valid && so_ready) begin
                tx_q.push_back(cur);
                last_tx_cyc = cyc;
                r = cur;
                if (pbeat == 0) r.d = {cur.d[55:48], cur.d[63:56], cur.d[47:0]};
                if (mode == 1 && ptag == 1 && pbeat == 3) r.d[0] = ~r.d[0];
                if (mode != 2) rep_q.push_back(r);
                if (cur.l) begin
                    $display("tx packet tag=%0d beats=%0d", ptag, pbeat + 1);
                    pbeat = 0;
                    ptag++;
                end else begin
                    pbeat++;
                end
            end
            prev_stall = so_valid && !so_ready;
            prev_b     = cur;
            if (rep_q.size() > 0 && !(rx_gaps && $urandom_range(0, 3) == 0)) begin
                {si_data, si_keep, si_last} = rep_q[0];
                si_valid = 1'b1;
            end else begin
                si_valid = 1'b0;
            end
            if (si_valid && si_ready) void'(rep_q.pop_front());
        end
    endtask

    task automatic test_reset();
        int n;
        sel = 1'b0;
        aux_resetn = 1'b0;
        clear_tb();
        @(negedge clk);
        total++; if ({so_valid, so_last, so_keep, so_data} !== '0) begin bad++; $display("FAIL reset_tx: got v=%0b d=%h k=%h want 0", so_valid, so_data, so_keep); end
        total++; if ({done_o, pass_o, err_o, pkt_o, si_ready} !== '0) begin bad++; $display("FAIL reset_status: got done=%0b pass=%0b err=%0d pkt=%0d rdy=%0b want 0", done_o, pass_o, err_o, pkt_o, si_ready); end
        @(negedge clk);
        aux_resetn = 1'b1;
        n = 0;
        while (!so_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        total++; if (n !== SD) begin bad++; $display("FAIL reset_start_delay: got %0d want %0d", n, SD); end
        total++; if (si_ready !== 1'b1) begin bad++; $display("FAIL reset_rx_ready: got %0b want 1", si_ready); end
        total++; if (so_data !== exp_q[0].d) begin bad++; $display("FAIL reset_first_hdr: got %h want %h", so_data, exp_q[0].d); end
    endtask

    task automatic test_loopback();
        sel = 1'b0;
        do_reset();
        run_loop(0, 1'b0, 1'b1, 0, 2000);
        total++; if (tx_q.size() !== exp_q.size()) begin bad++; $display("FAIL loop_tx_len: got %0d want %0d", tx_q.size(), exp_q.size()); end
        for (int i = 0; i < tx_q.size() && i < exp_q.size(); i++) begin
            total++; if (tx_q[i] !== exp_q[i]) begin bad++; $display("FAIL loop_tx_beat%0d: got %h want %h", i, tx_q[i], exp_q[i]); end
        end
        if (tx_q.size() >= NB + 1) begin
            total++; if (tx_q[NB].k !== 8'h0F) begin bad++; $display("FAIL loop_last_keep: got %h want 0f", tx_q[NB].k); end
        end
        total++; if ({done_o, pass_o} !== 2'b11) begin bad++; $display("FAIL loop_done_pass: got %0b%0b want 11", done_o, pass_o); end
        total++; if (err_o !== 16'd0) begin bad++; $display("FAIL loop_err: got %0d want 0", err_o); end
        total++; if (pkt_o !== 16'(NP)) begin bad++; $display("FAIL loop_pkts: got %0d want %0d", pkt_o, NP); end
        total++; if (thr_lows !== 0) begin bad++; $display("FAIL loop_rx_ready_low: got %0d want 0", thr_lows); end
    endtask

    task automatic test_extra_beat();
        si_data  = 64'(($urandom() << 32) | $urandom());
        si_keep  = 8'hFF;
        si_last  = 1'b0;
        si_valid = 1'b1;
        @(negedge clk);
        si_valid = 1'b0;
        @(negedge clk);
        total++; if (err_o !== 16'd1) begin bad++; $display("FAIL extra_err: got %0d want 1", err_o); end
        total++; if ({done_o, pass_o} !== 2'b10) begin bad++; $display("FAIL extra_done_pass: got %0b%0b want 10", done_o, pass_o); end
    endtask

    task automatic test_tx_stall();
        sel = 1'b0;
        do_reset();
        run_loop(0, 1'b1, 1'b1, 0, 3000);
        total++; if (stall_viol !== 0) begin bad++; $display("FAIL stall_stable: got %0d violations want 0", stall_viol); end
        total++; if (tx_q.size() !== exp_q.size()) begin bad++; $display("FAIL stall_tx_len: got %0d want %0d", tx_q.size(), exp_q.size()); end
        for (int i = 0; i < tx_q.size() && i < exp_q.size(); i++) begin
            total++; if (tx_q[i] !== exp_q[i]) begin bad++; $display("FAIL stall_tx_beat%0d: got %h want %h", i, tx_q[i], exp_q[i]); end
        end
        total++; if ({done_o, pass_o, err_o} !== {2'b11, 16'd0}) begin bad++; $display("FAIL stall_result: got done=%0b pass=%0b err=%0d want 1 1 0", done_o, pass_o, err_o); end
    endtask

    task automatic test_rx_throttle();
        sel = 1'b1;
        do_reset();
        run_loop(0, 1'b0, 1'b0, 0, 2000);
        total++; if (thr_viol !== 0) begin bad++; $display("FAIL thr_spacing: got %0d violations want 0", thr_viol); end
        total++; if (thr_lows < loop_cycles / 4 - 1) begin bad++; $display("FAIL thr_lows: got %0d want >= %0d", thr_lows, loop_cycles / 4 - 1); end
        total++; if (tx_q.size() !== exp_q.size()) begin bad++; $display("FAIL thr_tx_len: got %0d want %0d", tx_q.size(), exp_q.size()); end
        total++; if (pkt_o !== 16'(NP)) begin bad++; $display("FAIL thr_pkts: got %0d want %0d", pkt_o, NP); end
        total++; if ({done_o, pass_o, err_o} !== {2'b11, 16'd0}) begin bad++; $display("FAIL thr_result: got done=%0b pass=%0b err=%0d want 1 1 0", done_o, pass_o, err_o); end
        sel = 1'b0;
    endtask

    task automatic test_corrupt();
        sel = 1'b0;
        do_reset();
        run_loop(1, 1'b1, 1'b1, 0, 3000);
        total++; if (err_o !== 16'd1) begin bad++; $display("FAIL corrupt_err: got %0d want 1", err_o); end
        total++; if ({done_o, pass_o} !== 2'b10) begin bad++; $display("FAIL corrupt_done_pass: got %0b%0b want 10", done_o, pass_o); end
        total++; if (pkt_o !== 16'(NP)) begin bad++; $display("FAIL corrupt_pkts: got %0d want %0d", pkt_o, NP); end
    endtask

    task automatic test_timeout();
        sel = 1'b0;
        do_reset();
        run_loop(2, 1'b0, 1'b0, 0, 6000);
        total++; if ({done_o, pass_o} !== 2'b10) begin bad++; $display("FAIL timeout_done_pass: got %0b%0b want 10", done_o, pass_o); end
        total++; if (pkt_o !== 16'd0) begin bad++; $display("FAIL timeout_pkts: got %0d want 0", pkt_o); end
        total++; if (done_cyc - last_tx_cyc < TO - 1 || done_cyc - last_tx_cyc > TO + 1) begin bad++; $display("FAIL timeout_latency: got %0d want %0d", done_cyc - last_tx_cyc, TO); end
        total++; if (tx_q.size() !== exp_q.size()) begin bad++; $display("FAIL timeout_tx_len: got %0d want %0d", tx_q.size(), exp_q.size()); end
    endtask

    task automatic test_mid_reset();
        int n;
        sel = 1'b0;
        do_reset();
        run_loop(0, 1'b0, 1'b0, 2 * (NB + 1) + 3, 1000);
        total++; if (pkt_o !== 16'd2) begin bad++; $display("FAIL midrst_pre_pkts: got %0d want 2", pkt_o); end
        #2 aux_resetn = 1'b0;
        #1;
        total++; if ({so_valid, so_data, so_keep, so_last} !== '0) begin bad++; $display("FAIL midrst_tx_clear: got v=%0b d=%h want 0", so_valid, so_data); end
        total++; if ({done_o, pass_o, err_o, pkt_o, si_ready} !== '0) begin bad++; $display("FAIL midrst_status_clear: got pkt=%0d rdy=%0b done=%0b want 0", pkt_o, si_ready, done_o); end
        clear_tb();
        repeat (2) @(negedge clk);
        aux_resetn = 1'b1;
        n = 0;
        while (!so_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        total++; if (n !== SD) begin bad++; $display("FAIL midrst_start_delay: got %0d want %0d", n, SD); end
        total++; if (so_data !== exp_q[0].d) begin bad++; $display("FAIL midrst_hdr_tag0: got %h want %h", so_data, exp_q[0].d); end
        run_loop(0, 1'b1, 1'b0, 0, 3000);
        total++; if (tx_q.size() !== exp_q.size()) begin bad++; $display("FAIL midrst_tx_len: got %0d want %0d", tx_q.size(), exp_q.size()); end
        total++; if ({done_o, pass_o, pkt_o} !== {2'b11, 16'(NP)}) begin bad++; $display("FAIL midrst_result: got done=%0b pass=%0b pkt=%0d want 1 1 %0d", done_o, pass_o, pkt_o, NP); end
    endtask

    initial begin
        build_expected();
        test_reset();
        test_loopback();
        test_extra_beat();
        test_tx_stall();
        test_rx_throttle();
        test_corrupt();
        test_timeout();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
